// File: rtl/pwm_pkg.sv
// pwm_pkg -- constants and types shared by the PWM decoder slice.
//   Generator width constants and period, the midpoint thresholds derived from
//   them, the stuck-input timeout, the speed code type and the decoder FSM state.
package pwm_pkg;

    localparam int unsigned CNT_W      = 21;

    // Speed generator reference: period and nominal high widths per speed code
    localparam int unsigned GEN_PERIOD = 1 << 20;
    localparam int unsigned GEN_W0     = 0;
    localparam int unsigned GEN_W1     = 400000;
    localparam int unsigned GEN_W2     = 524288;
    localparam int unsigned GEN_W3     = 720000;

    // Decision thresholds sit midway between neighbouring generator widths
    localparam int unsigned TH1        = (GEN_W0 + GEN_W1) / 2;
    localparam int unsigned TH2        = (GEN_W1 + GEN_W2) / 2;
    localparam int unsigned TH3        = (GEN_W2 + GEN_W3) / 2;

    // 1.5 generator periods without an edge means the input is static
    localparam int unsigned TIMEOUT    = GEN_PERIOD + GEN_PERIOD / 2;

    typedef enum logic [1:0] {
        SPEED_0 = 2'd0,
        SPEED_1 = 2'd1,
        SPEED_2 = 2'd2,
        SPEED_3 = 2'd3
    } speed_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync -- three-flop synchronizer with edge detection.
//   clk, reset : system clock, synchronous active-high reset
//   async_i    : asynchronous input
//   level_o    : synchronized level (second flop)
//   rise_o     : one-cycle pulse on a synchronized rising edge
//   fall_o     : one-cycle pulse on a synchronized falling edge
module pwm_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s1 may be metastable; edges are taken between the two settled flops
    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder -- measures high time and period of an asynchronous PWM input
// and decodes the high time into a 2-bit speed code; flags a static input.
//   clk, reset  : system clock, synchronous active-high reset
//   en          : measurement enable; low forces IDLE and clears the counter
//   pwm_in      : asynchronous PWM input
//   high_time   : last measured high time in clk cycles
//   period      : last measured period in clk cycles
//   speed       : decoded speed code
//   meas_valid  : one-cycle pulse whenever the outputs above update
//   stuck       : input static for longer than TIMEOUT cycles
//   stuck_level : pwm_in level when stuck was declared
module pwm_decoder #(
    parameter int unsigned CNT_W   = pwm_pkg::CNT_W,
    parameter int unsigned TIMEOUT = pwm_pkg::TIMEOUT,
    parameter int unsigned TH1     = pwm_pkg::TH1,
    parameter int unsigned TH2     = pwm_pkg::TH2,
    parameter int unsigned TH3     = pwm_pkg::TH3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               pwm_in,
    output logic [CNT_W-1:0]   high_time,
    output logic [CNT_W-1:0]   period,
    output pwm_pkg::speed_t    speed,
    output logic               meas_valid,
    output logic               stuck,
    output logic               stuck_level
);

    import pwm_pkg::*;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TH1_C     = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] TH2_C     = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] TH3_C     = CNT_W'(TH3);

    logic level;
    logic rise;
    logic fall;

    pwm_edge_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (pwm_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_t           state_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] per_cnt_d;
    logic [CNT_W-1:0] hi_cap_q;
    logic [CNT_W-1:0] high_time_q;
    logic [CNT_W-1:0] period_q;
    speed_t           speed_q;
    logic             meas_valid_q;
    logic             stuck_q;
    logic             stuck_level_q;

    function automatic speed_t decode(input logic [CNT_W-1:0] h);
        if (h < TH1_C) begin
            return SPEED_0;
        end else if (h < TH2_C) begin
            return SPEED_1;
        end else if (h < TH3_C) begin
            return SPEED_2;
        end else begin
            return SPEED_3;
        end
    endfunction

    // Saturating increment: the counter never wraps, it parks at TIMEOUT
    always_comb begin
        per_cnt_d = per_cnt_q;
        if (per_cnt_q != TIMEOUT_C) begin
            per_cnt_d = per_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            per_cnt_q     <= '0;
            hi_cap_q      <= '0;
            high_time_q   <= '0;
            period_q      <= '0;
            speed_q       <= SPEED_0;
            meas_valid_q  <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (!en) begin
                state_q   <= ST_IDLE;
                per_cnt_q <= '0;
            end else if (rise) begin
                // Every rise restarts the period count; only a rise that
                // closes a full high+low cycle produces a measurement.
                per_cnt_q <= CNT_W'(1);
                state_q   <= ST_HIGH;
                if (state_q == ST_LOW) begin
                    period_q     <= per_cnt_q;
                    high_time_q  <= hi_cap_q;
                    speed_q      <= decode(hi_cap_q);
                    stuck_q      <= 1'b0;
                    meas_valid_q <= 1'b1;
                end
            end else if (fall) begin
                per_cnt_q <= per_cnt_d;
                if (state_q == ST_HIGH) begin
                    hi_cap_q <= per_cnt_q;
                    state_q  <= ST_LOW;
                end
            end else if (per_cnt_q == TIMEOUT_C) begin
                // Edges take priority, so this branch only sees a static input
                meas_valid_q  <= 1'b1;
                stuck_q       <= 1'b1;
                stuck_level_q <= level;
                high_time_q   <= '0;
                period_q      <= '0;
                speed_q       <= level ? SPEED_3 : SPEED_0;
                per_cnt_q     <= '0;
                state_q       <= ST_IDLE;
            end else begin
                per_cnt_q <= per_cnt_d;
            end
        end
    end

    assign high_time   = high_time_q;
    assign period      = period_q;
    assign speed       = speed_q;
    assign meas_valid  = meas_valid_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder -- randomized bench for pwm_decoder, scaled-down parameters.
//   The reference model works on timestamps: it remembers the cycle at which
//   the period count last restarted and derives counts by subtraction.
module tb_pwm_decoder;

    localparam int unsigned CW = 12;
    localparam int TO  = 384;   // 1.5 x 256-cycle scaled generator period
    localparam int GP  = 256;
    localparam int W1  = 98;
    localparam int W2  = 128;
    localparam int W3  = 176;
    localparam int T1  = 49;    // midpoints of 0/98/128/176
    localparam int T2  = 113;
    localparam int T3  = 152;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] high_time;
    logic [CW-1:0] period;
    pwm_pkg::speed_t speed;
    logic          meas_valid;
    logic          stuck;
    logic          stuck_level;

    pwm_decoder #(
        .CNT_W   (CW),
        .TIMEOUT (TO),
        .TH1     (T1),
        .TH2     (T2),
        .TH3     (T3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pwm_in      (pwm_in),
        .high_time   (high_time),
        .period      (period),
        .speed       (speed),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int cyc = 0;        // index of the clock edge being modelled
    int hist[$];        // pwm_in as seen by the synchronizer at past edges
    int t_base = 0;     // edge index at which the period count read zero
    int phase = 0;      // 0: waiting for first rise, 1: high, 2: low
    int hicap = 0;
    int e_high = 0, e_per = 0, e_spd = 0, e_mv = 0, e_stuck = 0, e_lvl = 0;
    int n_meas = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int speed_of(input int h);
        return int'(h >= T1) + int'(h >= T2) + int'(h >= T3);
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit p);
        int sz, lv2, lv3, age, cnt;
        bit rs, fl;
        sz  = hist.size();
        lv2 = hist[sz-2];   // sampled two edges ago
        lv3 = hist[sz-3];   // sampled three edges ago
        rs  = (lv2 == 1) && (lv3 == 0);
        fl  = (lv2 == 0) && (lv3 == 1);
        hist.push_back(p ? 1 : 0);
        if (hist.size() > 4) void'(hist.pop_front());
        e_mv = 0;
        age  = cyc - t_base;
        cnt  = (age > TO) ? TO : age;
        if (r) begin
            hist = '{0, 0, 0};
            phase = 0; hicap = 0; t_base = cyc + 1;
            e_high = 0; e_per = 0; e_spd = 0; e_stuck = 0; e_lvl = 0;
        end else if (!e) begin
            phase = 0; t_base = cyc + 1;
        end else if (rs) begin
            if (phase == 2) begin
                e_per = cnt; e_high = hicap; e_spd = speed_of(hicap);
                e_stuck = 0; e_mv = 1; n_meas++;
            end
            phase = 1; t_base = cyc;
        end else if (fl) begin
            if (phase == 1) begin
                hicap = cnt; phase = 2;
            end
        end else if (age >= TO) begin
            e_mv = 1; e_stuck = 1; e_lvl = lv2;
            e_high = 0; e_per = 0; e_spd = lv2 ? 3 : 0;
            phase = 0; t_base = cyc + 1;
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit p);
        @(negedge clk);
        reset = r; en = e; pwm_in = p;
        @(posedge clk);
        model_edge(r, e, p);
        #1;
        check_eq("meas_valid",  int'(meas_valid),  e_mv);
        check_eq("high_time",   int'(high_time),   e_high);
        check_eq("period",      int'(period),      e_per);
        check_eq("speed",       int'(speed),       e_spd);
        check_eq("stuck",       int'(stuck),       e_stuck);
        check_eq("stuck_level", int'(stuck_level), e_lvl);
        cyc++;
    endtask

    task automatic hold(input bit lvl, input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b1, lvl);
    endtask

    task automatic train(input int hi, input int per, input int count);
        for (int k = 0; k < count; k++) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    initial begin
        int hi, per;
        hist = '{0, 0, 0};

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);

        // Static low: periodic stuck reports at level 0
        hold(1'b0, 2 * (TO + 1) + 20);

        // Generator-like waveforms for each speed code
        train(W1, GP, 3);
        train(W2, GP, 2);
        train(W3, GP, 2);

        // Threshold boundaries
        train(T1 - 1, GP, 1); train(T1, GP, 1);
        train(T2 - 1, GP, 1); train(T2, GP, 1);
        train(T3 - 1, GP, 1); train(T3, GP, 2);

        // Static high, then resume
        hold(1'b1, 2 * (TO + 1) + 20);
        hold(1'b0, GP - W1);
        train(W1, GP, 3);

        // One-cycle reset while high, then a fresh measurement
        hold(1'b1, 30);
        tick(1'b1, 1'b1, 1'b1);
        hold(1'b1, 60);
        hold(1'b0, 150);
        train(W2, GP, 3);

        // Enable dropped while low, a rise occurs meanwhile
        train(W1, GP, 1);
        hold(1'b1, W1);
        hold(1'b0, 50);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, (i >= 40 && i < 80));
        hold(1'b0, 30);
        train(W1, GP, 3);

        // Static stretches close to the timeout (edge vs timeout races)
        for (int k = 0; k < 8; k++) begin
            hold(1'b1, $urandom_range(TO + 3, TO - 3));
            hold(1'b0, $urandom_range(TO + 3, TO - 3));
        end

        // Random waveforms with occasional enable drops and resets
        for (int k = 0; k < 40; k++) begin
            per = $urandom_range(600, 2);
            hi  = $urandom_range(per - 1, 1);
            train(hi, per, $urandom_range(3, 1));
            case ($urandom_range(9, 0))
                0: for (int i = 0; i < $urandom_range(20, 1); i++) tick(1'b0, 1'b0, $urandom_range(1, 0));
                1: tick(1'b1, 1'b1, $urandom_range(1, 0));
                2: hold($urandom_range(1, 0), $urandom_range(2 * TO, TO));
                default: ;
            endcase
        end

        hold(1'b0, 20);
        check_eq("measurement_count_nonzero", int'(n_meas > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
